// File: rtl/input_skew_buffer_if.sv
// Row-load / skewed-stream handshake bundle between the input buffer,
// the skew buffer and the systolic array.
interface input_skew_buffer_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N*DATA_WIDTH-1:0] inbuf_bus;
    logic                    inbuf_valid;
    logic                    inbuf_ready;
    logic [N*DATA_WIDTH-1:0] array_data;
    logic                    array_valid;
    logic                    array_enable;
    logic                    tile_last;

    // Environment side: supplies rows, consumes skewed steps.
    modport master (
        output inbuf_bus, inbuf_valid, array_enable,
        input  inbuf_ready, array_data, array_valid, tile_last
    );

    // Skew buffer side.
    modport slave (
        input  inbuf_bus, inbuf_valid, array_enable,
        output inbuf_ready, array_data, array_valid, tile_last
    );
endinterface

// File: rtl/input_skew_buffer.sv
// Collects an N x N tile row by row, then replays it to a systolic array
// as 2N-1 diagonally skewed lane vectors (lane j delayed by j steps).
module input_skew_buffer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    input_skew_buffer_if.slave  skew_if
);
    localparam int RW  = (N > 1) ? $clog2(N) : 1;
    localparam int SW  = (N > 1) ? $clog2(2*N - 1) : 1;
    localparam int SW1 = SW + 1;
    localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(2*N - 2);

    typedef enum logic {LOAD, STREAM} state_t;

    state_t                       state_q, state_d;
    logic [RW-1:0]                row_q, row_d;
    logic [SW-1:0]                step_q, step_d;
    logic [N-1:0][DATA_WIDTH-1:0] tile [N];
    logic [N-1:0][DATA_WIDTH-1:0] skew_vec;
    logic                         accept;

    assign accept = (state_q == LOAD) && skew_if.inbuf_valid;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            row_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            step_q  <= step_d;
        end
    end

    // Next-state, counter advance and handshake/status outputs.
    always_comb begin
        state_d              = state_q;
        row_d                = row_q;
        step_d               = step_q;
        skew_if.inbuf_ready  = 1'b0;
        skew_if.array_valid  = 1'b0;
        skew_if.tile_last    = 1'b0;
        case (state_q)
            LOAD: begin
                skew_if.inbuf_ready = 1'b1;
                if (skew_if.inbuf_valid) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        step_d  = '0;
                        state_d = STREAM;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            STREAM: begin
                skew_if.array_valid = 1'b1;
                skew_if.tile_last   = (step_q == STEP_LAST);
                if (skew_if.array_enable) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        state_d = LOAD;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Tile storage: accepted row goes to the slot named by the row counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            tile <= '{default: '0};
        end else if (accept) begin
            tile[row_q] <= skew_if.inbuf_bus;
        end
    end

    // Lane j shows tile[step-j][j]; the extra sign bit of diff flags step < j.
    for (genvar lane = 0; lane < N; lane++) begin : g_lane
        logic [SW:0] diff;
        logic        hit;
        assign diff = {1'b0, step_q} - SW1'(lane);
        assign hit  = (state_q == STREAM) && !diff[SW] && (diff[SW-1:0] <= SW'(N - 1));
        assign skew_vec[lane] = hit ? tile[diff[RW-1:0]][lane] : '0;
    end

    assign skew_if.array_data = skew_vec;
endmodule

// File: tb/tb_input_skew_buffer.sv
// Bench for input_skew_buffer at N=4, DATA_WIDTH=8: a vector table for the
// basic tile, then hand-written stall / sparse-valid / backpressure / reset /
// back-to-back sequences checked against a scoreboard of expected steps.
module tb_input_skew_buffer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    input_skew_buffer_if #(.N(4), .DATA_WIDTH(8)) bus ();

    input_skew_buffer #(.N(4), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .skew_if (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        en;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } step_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rows     [4];
    logic [31:0] skew_exp [7];
    vec_t        vecs     [12];
    step_t       sb_q [$];

    // Bench-side reference of the control flow.
    bit armed  = 1'b0;
    bit m_load = 1'b1;
    int m_rows = 0;
    int m_step = 0;

    // Observation counters, cleared per sequence.
    int obs_xfer   = 0;
    int obs_last   = 0;
    int obs_hold   = 0;
    int obs_accept = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference update at each edge; pushes the 7 expected steps on the 4th accept.
    always @(posedge clk) begin
        if (reset) begin
            armed  = 1'b1;
            m_load = 1'b1;
            m_rows = 0;
            m_step = 0;
            sb_q.delete();
        end else if (armed) begin
            if (m_load) begin
                if (bus.inbuf_valid) begin
                    m_rows++;
                    if (m_rows == 4) begin
                        m_rows = 0;
                        m_step = 0;
                        m_load = 1'b0;
                        for (int k = 0; k < 7; k++)
                            sb_q.push_back('{data: skew_exp[k], last: (k == 6)});
                    end
                end
            end else if (bus.array_enable) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                if (m_step == 6) begin
                    m_step = 0;
                    m_load = 1'b1;
                end else begin
                    m_step++;
                end
            end
        end
    end

    // Mid-cycle monitor: compares outputs with the reference and scoreboard.
    always @(negedge clk) begin
        if (armed) begin
            chk("mon_ready", {31'b0, bus.inbuf_ready}, {31'b0, m_load});
            chk("mon_valid", {31'b0, bus.array_valid}, {31'b0, !m_load});
            if (m_load) begin
                chk("mon_load_data", bus.array_data, 32'h0);
                chk("mon_load_last", {31'b0, bus.tile_last}, 32'h0);
            end else if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_sb_empty actual=%h required=<queued step>", bus.array_data);
            end else begin
                chk("mon_data", bus.array_data, sb_q[0].data);
                chk("mon_last", {31'b0, bus.tile_last}, {31'b0, sb_q[0].last});
            end
            if (bus.array_valid && bus.array_enable) begin
                obs_xfer++;
                if (bus.tile_last) obs_last++;
            end
            if (bus.array_valid && bus.array_data == 32'h04132231) obs_hold++;
            if (bus.inbuf_ready && bus.inbuf_valid) obs_accept++;
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [31:0] d, input logic e);
        reset            = r;
        bus.inbuf_valid  = v;
        bus.inbuf_bus    = d;
        bus.array_enable = e;
        @(posedge clk);
        #1;
    endtask

    task automatic feed();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, rows[i], 1'b1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic clear_obs();
        obs_xfer   = 0;
        obs_last   = 0;
        obs_hold   = 0;
        obs_accept = 0;
    endtask

    initial begin
        rows[0] = 32'h04030201;
        rows[1] = 32'h14131211;
        rows[2] = 32'h24232221;
        rows[3] = 32'h34333231;
        skew_exp[0] = 32'h00000001;
        skew_exp[1] = 32'h00000211;
        skew_exp[2] = 32'h00031221;
        skew_exp[3] = 32'h04132231;
        skew_exp[4] = 32'h14233200;
        skew_exp[5] = 32'h24330000;
        skew_exp[6] = 32'h34000000;

        //           valid data          en    rdy   avld  data          last
        vecs[0]  = '{1'b1, 32'h04030201, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 32'h14131211, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 32'h24232221, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 32'h34333231, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000001, 1'b0};
        vecs[5]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000211, 1'b0};
        vecs[6]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00031221, 1'b0};
        vecs[7]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h04132231, 1'b0};
        vecs[8]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h14233200, 1'b0};
        vecs[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h24330000, 1'b0};
        vecs[10] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h34000000, 1'b1};
        vecs[11] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0};

        // Reset with inputs active: reset must win.
        reset            = 1'b1;
        bus.inbuf_valid  = 1'b1;
        bus.inbuf_bus    = rows[0];
        bus.array_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.inbuf_valid = 1'b0;

        // Basic tile, cycle by cycle from the table.
        for (int i = 0; i < 12; i++) begin
            bus.inbuf_valid  = vecs[i].valid;
            bus.inbuf_bus    = vecs[i].data;
            bus.array_enable = vecs[i].en;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), {31'b0, bus.inbuf_ready}, {31'b0, vecs[i].exp_ready});
            chk($sformatf("vec%0d_valid", i), {31'b0, bus.array_valid}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i),  bus.array_data,           vecs[i].exp_data);
            chk($sformatf("vec%0d_last", i),  {31'b0, bus.tile_last},   {31'b0, vecs[i].exp_last});
            @(posedge clk);
            #1;
        end

        // Stall for 3 cycles while step 3 is shown.
        clear_obs();
        feed();
        run(3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        run(4);
        chk("stall_transfers", obs_xfer, 7);
        chk("stall_hold_cycles", obs_hold, 4);
        chk("stall_last_pulses", obs_last, 1);

        // Sparse valid during LOAD.
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, rows[i], 1'b1);
            if (i < 3) cyc(1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
        end
        run(7);
        chk("sparse_accepts", obs_accept, 4);
        chk("sparse_transfers", obs_xfer, 7);

        // Next tile's R0 held during STREAM: accepted only on the first LOAD cycle.
        feed();
        clear_obs();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, rows[0], 1'b1);
        chk("hold_r0_accepts", obs_accept, 1);
        for (int i = 1; i < 4; i++) cyc(1'b0, 1'b1, rows[i], 1'b1);
        run(7);
        chk("hold_r0_transfers", obs_xfer, 14);

        // Reset at step 2, then a fresh tile.
        feed();
        run(2);
        cyc(1'b1, 1'b1, rows[0], 1'b1);
        clear_obs();
        feed();
        run(7);
        chk("reset_mid_accepts", obs_accept, 4);
        chk("reset_mid_transfers", obs_xfer, 7);
        chk("reset_mid_last", obs_last, 1);

        // Two back-to-back tiles: 22 cycles, two tile_last pulses.
        clear_obs();
        feed();
        run(7);
        feed();
        run(7);
        @(negedge clk);
        chk("b2b_ready_after_22", {31'b0, bus.inbuf_ready}, 32'h1);
        chk("b2b_last_pulses", obs_last, 2);
        chk("b2b_transfers", obs_xfer, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
